// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: word array with byte/halfword/word lanes, programmable
// wait states, two-cycle ERROR response and a saturating error counter.
module ahb_sram_slave #(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [31:0] HWDATA,
    output logic        HREADY,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    output logic [7:0]  err_count
);

    localparam int unsigned AW        = $clog2(MEM_WORDS);
    localparam logic [31:0] WIN_BYTES = 32'(4 * MEM_WORDS);
    localparam logic [2:0]  WS        = 3'(WAIT_STATES);

    typedef enum logic [1:0] {S_OK, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t          state;
    logic [2:0]      wait_cnt;
    logic            dp_valid;
    logic            dp_write;
    logic [AW-1:0]   dp_idx;
    logic [2:0]      dp_size;
    logic [1:0]      dp_lane;
    logic [31:0]     mem [MEM_WORDS];

    logic [32:0]     off_full;
    logic            accept;
    logic            legal;
    logic [AW-1:0]   a_idx;
    logic            mem_we;
    logic [3:0]      wr_mask;
    logic [31:0]     wr_word;
    logic            rd_fire;
    logic [AW-1:0]   rd_idx;
    logic [31:0]     rd_word;
    logic            unused_bits;

    // Bit 32 of the 33-bit difference is the borrow, i.e. HADDR below the window.
    assign off_full = {1'b0, HADDR} - {1'b0, ADDR_BASE};
    assign accept   = HREADY & HSEL & HTRANS[1];
    assign legal    = (HSIZE <= 3'd2)
                    && !(HSIZE == 3'd1 && HADDR[0])
                    && !(HSIZE == 3'd2 && HADDR[1:0] != 2'b00)
                    && !off_full[32]
                    && (off_full[31:0] < WIN_BYTES);
    assign a_idx    = off_full[AW+1:2];
    assign unused_bits = ^{HBURST, HTRANS[0]};

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lane);
        case (size)
            3'd0:    lane_mask = 4'b0001 << lane;
            3'd1:    lane_mask = lane[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    assign mem_we  = dp_valid & dp_write & HREADY;
    assign wr_mask = lane_mask(dp_size, dp_lane);

    always_comb begin
        wr_word = mem[dp_idx];
        for (int i = 0; i < 4; i++) begin
            if (wr_mask[i]) wr_word[8*i +: 8] = HWDATA[8*i +: 8];
        end
    end

    // Read data is registered one edge ahead of the cycle that shows it; a write
    // completing on that same edge is forwarded so back-to-back RAW sees new lanes.
    assign rd_fire = (accept && legal && !HWRITE && WS == 3'd0)
                   || (state == S_WAIT && wait_cnt == 3'd1 && !dp_write);
    assign rd_idx  = (state == S_WAIT) ? dp_idx : a_idx;
    assign rd_word = (mem_we && dp_idx == rd_idx) ? wr_word : mem[rd_idx];

    always_ff @(posedge HCLK) begin
        if (mem_we) mem[dp_idx] <= wr_word;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= S_OK;
            wait_cnt  <= 3'd0;
            HREADY    <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= 32'h0;
            err_count <= 8'h0;
            dp_valid  <= 1'b0;
            dp_write  <= 1'b0;
            dp_idx    <= '0;
            dp_size   <= 3'd0;
            dp_lane   <= 2'd0;
        end else begin
            HRDATA <= rd_fire ? rd_word : 32'h0;
            if (HREADY) begin
                dp_valid <= accept & legal;
                dp_write <= HWRITE;
                dp_idx   <= a_idx;
                dp_size  <= HSIZE;
                dp_lane  <= HADDR[1:0];
            end
            case (state)
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 3'd1;
                    if (wait_cnt == 3'd1) begin
                        state  <= S_OK;
                        HREADY <= 1'b1;
                    end
                end
                S_ERR1: begin
                    state  <= S_ERR2;
                    HREADY <= 1'b1;
                    HRESP  <= 1'b1;
                end
                default: begin
                    if (accept && !legal) begin
                        state  <= S_ERR1;
                        HREADY <= 1'b0;
                        HRESP  <= 1'b1;
                        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                    end else if (accept && WS != 3'd0) begin
                        state    <= S_WAIT;
                        wait_cnt <= WS;
                        HREADY   <= 1'b0;
                        HRESP    <= 1'b0;
                    end else begin
                        state  <= S_OK;
                        HREADY <= 1'b1;
                        HRESP  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: two instances (zero and three wait states) share one
// bus driver; a byte-addressed reference memory feeds an expected-response queue.
module tb_ahb_sram_slave;

    localparam int unsigned MW    = 64;
    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE3 = 32'h0000_1000;
    localparam int          EW    = 37;

    logic        HCLK;
    logic        HRESETn;
    logic        hsel;
    logic        hwrite;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        sel;

    logic        hsel0, hsel3;
    logic        hready0, hready3, hresp0, hresp3;
    logic [31:0] hrdata0, hrdata3;
    logic [7:0]  err_count0, err_count3;
    logic        hready_m, hresp_m;
    logic [31:0] hrdata_m;

    logic [7:0]     ref_bytes [2][4*MW];
    int             err_model [2];
    logic [EW-1:0]  exp_q[$];
    int             n_cmp;
    int             n_err;
    bit             in_dp;
    int             lowcnt;

    assign hsel0    = hsel & ~sel;
    assign hsel3    = hsel & sel;
    assign hready_m = sel ? hready3 : hready0;
    assign hresp_m  = sel ? hresp3  : hresp0;
    assign hrdata_m = sel ? hrdata3 : hrdata0;

    ahb_sram_slave #(.ADDR_BASE(BASE0), .MEM_WORDS(MW), .WAIT_STATES(0)) u_dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADY(hready0), .HRESP(hresp0), .HRDATA(hrdata0), .err_count(err_count0)
    );

    ahb_sram_slave #(.ADDR_BASE(BASE3), .MEM_WORDS(MW), .WAIT_STATES(3)) u_dut3 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel3), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HWDATA(hwdata),
        .HREADY(hready3), .HRESP(hresp3), .HRDATA(hrdata3), .err_count(err_count3)
    );

    // Clock and reset
    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached with %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s", name);
    endtask

    // Reference model
    function automatic logic [31:0] base_of(input logic s);
        return s ? BASE3 : BASE0;
    endfunction

    function automatic int ws_of(input logic s);
        return s ? 3 : 0;
    endfunction

    function automatic bit is_legal(input logic [31:0] addr, input logic [2:0] size,
                                    input logic [31:0] base);
        longint a, b, nbytes;
        a = longint'(addr);
        b = longint'(base);
        if (size > 3'd2) return 1'b0;
        nbytes = longint'(1) << size;
        if (a % nbytes != 0) return 1'b0;
        if (a < b) return 1'b0;
        if (a - b >= longint'(4 * MW)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_access(input logic s, input logic wr, input logic [31:0] addr,
                                input logic [2:0] size, input logic [31:0] wdata,
                                output logic [EW-1:0] item);
        int si, off, w, lane;
        logic [31:0] data;
        si = int'(s);
        if (!is_legal(addr, size, base_of(s))) begin
            if (err_model[si] < 255) err_model[si]++;
            item = {1'b1, 4'd1, 32'h0};
            return;
        end
        off = int'(addr - base_of(s));
        if (wr) begin
            for (int b = 0; b < (1 << size); b++) begin
                lane = (off + b) % 4;
                ref_bytes[si][off + b] = wdata[8*lane +: 8];
            end
            item = {1'b0, 4'(ws_of(s)), 32'h0};
        end else begin
            w = off - (off % 4);
            data = {ref_bytes[si][w+3], ref_bytes[si][w+2], ref_bytes[si][w+1], ref_bytes[si][w]};
            item = {1'b0, 4'(ws_of(s)), data};
        end
    endtask

    // Driver tasks: every call starts and ends 2 time units after a rising edge.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] wdata, input logic [1:0] trans, input bit track);
        logic [EW-1:0] item;
        bit acc;
        if (track) begin
            model_access(sel, wr, addr, size, wdata, item);
            exp_q.push_back(item);
        end
        hsel   = 1'b1;
        htrans = trans;
        haddr  = addr;
        hwrite = wr;
        hsize  = size;
        hburst = 3'($urandom_range(0, 7));
        for (int i = 0; i < 64; i++) begin
            acc = hready_m;
            @(posedge HCLK);
            #2;
            if (acc) begin
                hwdata = wdata;
                hsel   = 1'b0;
                htrans = 2'b00;
                return;
            end
        end
        fail("accept_timeout");
        hsel   = 1'b0;
        htrans = 2'b00;
    endtask

    task automatic idle_cycle(input bit randomize_ctrl);
        if (randomize_ctrl) begin
            hsel   = 1'($urandom_range(0, 1));
            htrans = hsel ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
            haddr  = $urandom;
        end else begin
            hsel   = 1'b0;
            htrans = 2'b00;
        end
        @(posedge HCLK);
        #2;
        hsel   = 1'b0;
        htrans = 2'b00;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0 && !in_dp) return;
            idle_cycle(1'b0);
        end
        fail("drain_timeout");
        exp_q.delete();
    endtask

    task automatic check_err_counts();
        check("err_count0", {24'h0, err_count0}, 32'(err_model[0]));
        check("err_count3", {24'h0, err_count3}, 32'(err_model[1]));
    endtask

    // Scoreboard monitor: samples on the falling edge, pops on data-phase completion.
    initial begin
        logic [EW-1:0] item;
        in_dp  = 1'b0;
        lowcnt = 0;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                in_dp  = 1'b0;
                lowcnt = 0;
            end else begin
                if (in_dp) begin
                    if (exp_q.size() == 0) begin
                        fail("queue_underflow");
                        in_dp = 1'b0;
                    end else if (!hready_m) begin
                        lowcnt++;
                        check("wait_hresp", {31'h0, hresp_m}, {31'h0, exp_q[0][36]});
                        check("wait_hrdata", hrdata_m, 32'h0);
                    end else begin
                        item = exp_q.pop_front();
                        check("hresp", {31'h0, hresp_m}, {31'h0, item[36]});
                        check("hrdata", hrdata_m, item[31:0]);
                        check("wait_cycles", 32'(lowcnt), {28'h0, item[35:32]});
                        in_dp = 1'b0;
                    end
                end else begin
                    check("idle_hready", {31'h0, hready_m}, 32'h1);
                    check("idle_hresp", {31'h0, hresp_m}, 32'h0);
                    check("idle_hrdata", hrdata_m, 32'h0);
                end
                if (hready_m && hsel && htrans[1]) begin
                    in_dp  = 1'b1;
                    lowcnt = 0;
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic [31:0] a, base;
        logic [2:0]  sz;
        int          off;
        n_cmp = 0;
        n_err = 0;
        err_model[0] = 0;
        err_model[1] = 0;
        HRESETn = 1'b0;
        sel = 1'b0;
        hsel = 1'b0; htrans = 2'b00; haddr = 32'h0; hwrite = 1'b0;
        hsize = 3'd2; hburst = 3'd0; hwdata = 32'h0;

        #23;
        check("rst_hready0", {31'h0, hready0}, 32'h1);
        check("rst_hready3", {31'h0, hready3}, 32'h1);
        check("rst_hresp0", {31'h0, hresp0}, 32'h0);
        check("rst_hresp3", {31'h0, hresp3}, 32'h0);
        check("rst_hrdata0", hrdata0, 32'h0);
        check("rst_hrdata3", hrdata3, 32'h0);
        check_err_counts();
        @(posedge HCLK);
        #2;
        HRESETn = 1'b1;
        idle_cycle(1'b0);

        // Preload both memories so every later read has a known answer.
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            for (int i = 0; i < int'(MW); i++)
                issue(1'b1, base_of(sel) + 32'(4 * i), 3'd2, $urandom, 2'b10, 1'b1);
            drain();
        end

        // Zero-wait word write/read, lane merges, back-to-back forwarding.
        sel = 1'b0;
        issue(1'b1, 32'h10, 3'd2, 32'hDEAD_BEEF, 2'b10, 1'b1);
        issue(1'b0, 32'h10, 3'd2, $urandom, 2'b10, 1'b1);
        idle_cycle(1'b0);
        issue(1'b1, 32'h13, 3'd0, {8'hAA, 24'($urandom)}, 2'b10, 1'b1);
        issue(1'b1, 32'h10, 3'd1, {16'($urandom), 16'h1234}, 2'b11, 1'b1);
        issue(1'b0, 32'h10, 3'd2, $urandom, 2'b11, 1'b1);
        idle_cycle(1'b0);
        issue(1'b1, 32'h20, 3'd2, 32'h5555_5555, 2'b10, 1'b1);
        issue(1'b0, 32'h20, 3'd2, $urandom, 2'b11, 1'b1);
        drain();

        // Illegal transfers: misaligned word and one past the window (aliases word 0).
        issue(1'b1, 32'h02, 3'd2, $urandom, 2'b10, 1'b1);
        issue(1'b1, 32'(4 * MW), 3'd2, $urandom, 2'b10, 1'b1);
        issue(1'b0, 32'h00, 3'd2, $urandom, 2'b10, 1'b1);
        drain();
        check_err_counts();

        // Three-wait-state burst of reads.
        sel = 1'b1;
        issue(1'b0, BASE3 + 32'h20, 3'd2, 32'h0, 2'b10, 1'b1);
        issue(1'b0, BASE3 + 32'h24, 3'd2, 32'h0, 2'b11, 1'b1);
        issue(1'b0, BASE3 + 32'h28, 3'd2, 32'h0, 2'b11, 1'b1);
        drain();

        // Randomized traffic, alternating between the two instances.
        for (int ph = 0; ph < 4; ph++) begin
            sel  = 1'(ph % 2);
            base = base_of(sel);
            for (int k = 0; k < 80; k++) begin
                if ($urandom_range(0, 99) < 10) begin
                    idle_cycle(1'b1);
                end else begin
                    sz = ($urandom_range(0, 19) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
                    case ($urandom_range(0, 19))
                        0: a = base - 32'($urandom_range(1, 16));
                        1: a = base + 32'(4 * MW) + 32'($urandom_range(0, 15));
                        default: begin
                            off = $urandom_range(0, 4 * MW - 1);
                            a = base + 32'(off);
                            if (sz < 3'd3 && $urandom_range(0, 7) != 0)
                                a = a & ~((32'd1 << sz) - 32'd1);
                        end
                    endcase
                    issue(1'($urandom_range(0, 1)), a, sz, $urandom,
                          ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10, 1'b1);
                end
            end
            drain();
            check_err_counts();
        end

        // Reset in the middle of a waited write: the write must be lost.
        sel = 1'b1;
        issue(1'b1, BASE3 + 32'h8, 3'd2, 32'hCAFE_F00D, 2'b10, 1'b0);
        check("pre_rst_hready", {31'h0, hready3}, 32'h0);
        #1;
        HRESETn = 1'b0;
        #1;
        check("midrst_hready", {31'h0, hready3}, 32'h1);
        check("midrst_hresp", {31'h0, hresp3}, 32'h0);
        err_model[0] = 0;
        err_model[1] = 0;
        @(posedge HCLK);
        #2;
        HRESETn = 1'b1;
        idle_cycle(1'b0);
        idle_cycle(1'b0);
        issue(1'b0, BASE3 + 32'h8, 3'd2, 32'h0, 2'b10, 1'b1);
        drain();
        check_err_counts();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
